regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: the ALU path and the load/memory path.
- Keeps a 32-entry busy scoreboard of destination registers with outstanding writes, and flags read-after-write and write-after-write hazards to the decode stage.
- Sits between the execute/memory stages and register_file. It drives that block's write enable, destination address and write data through one registered stage.

Parameters:
- XLEN, 32, data width of writeback values
- NREGS, 32, number of architectural registers (x0 hardwired to zero)
- AW, 5, register address width; must satisfy 2**AW == NREGS

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- alu_wb_valid  in  1  ALU has a result to write
- alu_wb_ready  out  1  ALU result accepted this cycle
- alu_wb_rd  in  AW  ALU destination register
- alu_wb_data  in  XLEN  ALU result
- mem_wb_valid  in  1  load path has a result to write
- mem_wb_ready  out  1  load result accepted this cycle
- mem_wb_rd  in  AW  load destination register
- mem_wb_data  in  XLEN  load result
- issue_valid  in  1  decode issues an instruction that writes issue_rd
- issue_rd  in  AW  destination of the issuing instruction
- rs1  in  AW  source 1 of the instruction in decode
- rs2  in  AW  source 2 of the instruction in decode
- hazard  out  1  decode must stall
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)

Behaviour:
- Reset (async, reset_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - busy[] all 0
  - last_grant=MEM, so the ALU wins the first tie
  - Reset mid-transfer drops any in-flight write; nothing is written.
- Arbitration (combinational, each cycle):
  - Only one valid requester: it is granted.
  - Both valid: the one not in last_grant is granted (round-robin).
  - Neither valid: no grant; last_grant holds.
  - Exactly one of alu_wb_ready/mem_wb_ready is high when any request is valid; both are 0 otherwise.
  - ready does not depend on ready; a requester holds rd/data stable until its own ready=1.
- Handshake: a transfer occurs when valid&&ready in the same cycle. The requester may change or drop valid on the next cycle.
- Write stage, one cycle latency:
  - On a transfer with rd!=0 at edge N: rf_we=1, rf_waddr=rd, rf_wdata=data during cycle N+1, and last_grant updates to the winner.
  - No transfer: rf_we=0; rf_waddr and rf_wdata hold their previous values.
  - Transfer with rd==0: handshake completes and last_grant updates, but rf_we stays 0 (x0 write suppressed).
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - Clear: a committed write (rf_we=1 in cycle N+1) clears busy[rf_waddr] at the end of that cycle.
  - Same register set and cleared on the same edge: set wins, since a newer write is pending.
  - Setting an already-set bit leaves it set.
  - x0 is never busy.
- Hazard (combinational) is 1 when any of these holds:
  - rs1!=0 && busy[rs1]
  - rs2!=0 && busy[rs2]
  - issue_valid && issue_rd!=0 && busy[issue_rd] (WAW)
- Write bypass: none. A register becomes readable the cycle after rf_we commits, because busy clears at the end of the commit cycle.
- Decode must not assert issue_valid while hazard=1. If it does, the block still sets the bit; no error is flagged.
- Throughput: one write per cycle, sustained.

Test Plan:
- Reset, then ALU-only: alu_wb_valid=1, rd=5, data=0x0000_00AA for one cycle → alu_wb_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_00AA; rf_we=0 the cycle after.
- Tie alternation: ALU (rd=3, 0x11) and MEM (rd=4, 0x22) both held valid for 4 cycles from reset → grants ALU, MEM, ALU, MEM; rf_waddr sequence 3, 4, 3, 4 one cycle later.
- x0 suppression: mem_wb_valid=1, rd=0, data=0xFFFF_FFFF → mem_wb_ready=1; rf_we stays 0; hazard with rs1=0 stays 0.
- Scoreboard RAW:
  - Issue rd=7 → next cycle, rs1=7 gives hazard=1.
  - ALU writes rd=7 → hazard stays 1 during the rf_we cycle, then 0 the cycle after.
- Set/clear collision: on the edge ending the rf_we cycle for rd=9, issue_valid=1 with issue_rd=9 → busy[9] remains 1; rs2=9 gives hazard=1; issuing issue_rd=9 again gives hazard=1 (WAW).
- Async reset mid-operation: pull reset_n low between the transfer edge and the commit edge of a rd=12 write → rf_we=0 immediately, no write occurs, all busy bits 0, hazard=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin ALU/MEM arbiter for the register-file write port,
//            with a destination busy scoreboard for RAW/WAW stall detection.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            alu_wb_valid,
  output logic            alu_wb_ready,
  input  logic [AW-1:0]   alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  input  logic            mem_wb_valid,
  output logic            mem_wb_ready,
  input  logic [AW-1:0]   mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam logic [AW-1:0] c_x0 = '0;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]  busy_q, busy_d;

  logic              w_grant_alu;
  logic              w_grant_mem;
  logic              w_transfer;
  logic [AW-1:0]     w_win_rd;
  logic [XLEN-1:0]   w_win_data;

  // The requester that did not win last time gets priority on a tie.
  always_comb begin
    w_grant_alu = alu_wb_valid && (!mem_wb_valid || (last_grant_q == GRANT_MEM));
    w_grant_mem = mem_wb_valid && !w_grant_alu;
    w_transfer  = w_grant_alu || w_grant_mem;
    w_win_rd    = w_grant_alu ? alu_wb_rd   : mem_wb_rd;
    w_win_data  = w_grant_alu ? alu_wb_data : mem_wb_data;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    busy_d       = busy_q;

    if (w_transfer) begin
      last_grant_d = w_grant_alu ? GRANT_ALU : GRANT_MEM;
      if (w_win_rd != c_x0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = w_win_rd;
        rf_wdata_d = w_win_data;
      end
    end

    // Clear first so a same-edge issue to the same register keeps it busy.
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != c_x0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_MEM;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    hazard = ((rs1 != c_x0) && busy_q[rs1]) ||
             ((rs2 != c_x0) && busy_q[rs2]) ||
             (issue_valid && (issue_rd != c_x0) && busy_q[issue_rd]);
  end

  assign alu_wb_ready = w_grant_alu;
  assign mem_wb_ready = w_grant_mem;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Vector table, async-reset sequence and randomized model check.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_wb_valid = 1'b0, mem_wb_valid = 1'b0, issue_valid = 1'b0;
  logic        alu_wb_ready, mem_wb_ready, hazard, rf_we;
  logic [4:0]  alu_wb_rd = '0, mem_wb_rd = '0, issue_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] alu_wb_data = '0, mem_wb_data = '0;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
    .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        av; logic [4:0] ard; logic [31:0] adata;
    logic        mv; logic [4:0] mrd; logic [31:0] mdata;
    logic        iv; logic [4:0] ird; logic [4:0] r1; logic [4:0] r2;
    logic        ear; logic emr; logic ehz;
    logic        ewe; logic [4:0] ewa; logic [31:0] ewd;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] adata,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
    input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
    input logic ear, input logic emr, input logic ehz,
    input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.ear = ear; v.emr = emr; v.ehz = ehz;
    v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
    alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = adata;
    mem_wb_valid = mv; mem_wb_rd = mrd; mem_wb_data = mdata;
    issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Reference model state for the randomized phase
  bit          m_busy[32];
  bit          m_last_alu;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          acc_a, acc_m, ga, gm, ehz;
  logic [4:0]  wrd;

  initial begin
    //          av ard  adata         mv mrd mdata         iv ird r1 r2  ar mr hz  we wa wd
    tbl[0]  = mk(1, 3, 32'h11,        1, 4, 32'h22,        0, 0, 0, 0,  1, 0, 0,  0, 0, 32'h0);
    tbl[1]  = mk(1, 3, 32'h11,        1, 4, 32'h22,        0, 0, 0, 0,  0, 1, 0,  1, 3, 32'h11);
    tbl[2]  = mk(1, 3, 32'h11,        1, 4, 32'h22,        0, 0, 0, 0,  1, 0, 0,  1, 4, 32'h22);
    tbl[3]  = mk(1, 3, 32'h11,        1, 4, 32'h22,        0, 0, 0, 0,  0, 1, 0,  1, 3, 32'h11);
    tbl[4]  = mk(1, 5, 32'hAA,        0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 0,  1, 4, 32'h22);
    tbl[5]  = mk(0, 0, 32'h0,         1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0,  0, 1, 0,  1, 5, 32'hAA);
    tbl[6]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0,  0, 5, 32'hAA);
    tbl[7]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 7, 0, 0,  0, 0, 0,  0, 5, 32'hAA);
    tbl[8]  = mk(1, 7, 32'h77,        0, 0, 32'h0,         0, 0, 7, 0,  1, 0, 1,  0, 5, 32'hAA);
    tbl[9]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 7, 0,  0, 0, 1,  1, 7, 32'h77);
    tbl[10] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 7, 0,  0, 0, 0,  0, 7, 32'h77);
    tbl[11] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 9, 0, 0,  0, 0, 0,  0, 7, 32'h77);
    tbl[12] = mk(1, 9, 32'h99,        0, 0, 32'h0,         0, 0, 0, 9,  1, 0, 1,  0, 7, 32'h77);
    tbl[13] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 9, 0, 0,  0, 0, 1,  1, 9, 32'h99);
    tbl[14] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 9,  0, 0, 1,  0, 9, 32'h99);
    tbl[15] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 9, 0, 0,  0, 0, 1,  0, 9, 32'h99);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl%0d.rf_we", i), {31'b0, rf_we}, {31'b0, tbl[i].ewe});
      chk($sformatf("tbl%0d.rf_waddr", i), {27'b0, rf_waddr}, {27'b0, tbl[i].ewa});
      chk($sformatf("tbl%0d.rf_wdata", i), rf_wdata, tbl[i].ewd);
      drive(tbl[i].av, tbl[i].ard, tbl[i].adata, tbl[i].mv, tbl[i].mrd, tbl[i].mdata,
            tbl[i].iv, tbl[i].ird, tbl[i].r1, tbl[i].r2);
      #1;
      chk($sformatf("tbl%0d.alu_ready", i), {31'b0, alu_wb_ready}, {31'b0, tbl[i].ear});
      chk($sformatf("tbl%0d.mem_ready", i), {31'b0, mem_wb_ready}, {31'b0, tbl[i].emr});
      chk($sformatf("tbl%0d.hazard", i), {31'b0, hazard}, {31'b0, tbl[i].ehz});
      @(negedge clock);
    end

    // Async reset between the transfer edge and the commit edge of an rd=12 write
    drive(1, 12, 32'hC12, 0, 0, 0, 1, 12, 12, 0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.rf_we_now", {31'b0, rf_we}, 32'h0);
    chk("arst.rf_waddr_now", {27'b0, rf_waddr}, 32'h0);
    chk("arst.hazard_now", {31'b0, hazard}, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12, 9);
    @(posedge clock);
    #1;
    chk("arst.rf_we_held", {31'b0, rf_we}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 12, 9);
    #1;
    chk("arst.hazard_after", {31'b0, hazard}, 32'h0);
    chk("arst.alu_wins_tie", {31'b0, alu_wb_ready}, 32'h1);
    chk("arst.mem_loses_tie", {31'b0, mem_wb_ready}, 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    m_last_alu = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    acc_a = 1'b1; acc_m = 1'b1;
    for (int n = 0; n < 500; n++) begin
      chk("rnd.rf_we", {31'b0, rf_we}, {31'b0, m_we});
      chk("rnd.rf_waddr", {27'b0, rf_waddr}, {27'b0, m_wa});
      chk("rnd.rf_wdata", rf_wdata, m_wd);
      if (!(alu_wb_valid && !acc_a)) begin
        alu_wb_valid = ($urandom_range(0, 3) != 0);
        alu_wb_rd    = 5'($urandom_range(0, 7));
        alu_wb_data  = $urandom;
      end
      if (!(mem_wb_valid && !acc_m)) begin
        mem_wb_valid = ($urandom_range(0, 2) != 0);
        mem_wb_rd    = 5'($urandom_range(0, 7));
        mem_wb_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      #1;
      ga  = alu_wb_valid && (!mem_wb_valid || !m_last_alu);
      gm  = mem_wb_valid && !ga;
      ehz = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]) ||
            (issue_valid && issue_rd != 0 && m_busy[issue_rd]);
      chk("rnd.alu_ready", {31'b0, alu_wb_ready}, {31'b0, ga});
      chk("rnd.mem_ready", {31'b0, mem_wb_ready}, {31'b0, gm});
      chk("rnd.hazard", {31'b0, hazard}, {31'b0, ehz});
      @(posedge clock);
      if (m_we) m_busy[m_wa] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (ga || gm) begin
        wrd        = ga ? alu_wb_rd : mem_wb_rd;
        m_last_alu = ga;
        m_we       = (wrd != 0);
        if (m_we) begin
          m_wa = wrd;
          m_wd = ga ? alu_wb_data : mem_wb_data;
        end
      end else begin
        m_we = 1'b0;
      end
      acc_a = ga;
      acc_m = gm;
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
